// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches to instruction memory, buffers
// returned words in a DEPTH-entry prefetch FIFO and presents them to decode over valid/ready.
// Define IF_EARLY_BRANCH_EN to resolve unconditional B/BR at fetch; otherwise every returned
// word is passed through untouched and the PC only advances by +4 or an external redirect.
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic [2:0]  br_addr,
  input  logic [31:0] br_value
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       head_instr_q, head_instr_d;
  logic [31:0]       head_pc_q, head_pc_d;
  logic [31:0]       mem_instr_q [DEPTH];
  logic [31:0]       mem_pc_q    [DEPTH];

  logic [CntW-1:0]   credit_sum;
  logic              credit_ok;
  logic              enq, deq, branch_act, head_bypass;
  logic              br_taken;
  logic [31:0]       br_target;

  assign im_addr     = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = head_instr_q;
  assign instr_pc    = head_pc_q;

  // Credit check: a request is only issued if its response is guaranteed a FIFO slot.
  always_comb begin
    credit_sum = count_q + CntW'(rsp_valid_q);
    credit_ok  = (credit_sum < CntW'(DEPTH));
    state_d    = state_q;
    unique case (state_q)
      StRun:   if (!credit_ok) state_d = StHold;
      StHold:  if (credit_ok)  state_d = StRun;
      default: state_d = StRun;
    endcase
    im_req = credit_ok & ~reset;
  end

`ifdef IF_EARLY_BRANCH_EN
  localparam logic [6:0] OpB  = 7'b1100000;
  localparam logic [6:0] OpBr = 7'b1100010;

  logic [6:0]  opcode;
  logic [31:0] br_off, br_base, br_sum;
  logic        is_b, is_br;

  // Early decode of the word arriving from IM; BR reads its base register combinationally.
  always_comb begin
    opcode    = im_rdata[31:25];
    is_b      = rsp_valid_q && (opcode == OpB);
    is_br     = rsp_valid_q && (opcode == OpBr);
    br_off    = {{16{im_rdata[15]}}, im_rdata[15:0]};
    br_addr   = is_br ? im_rdata[24:22] : 3'b000;
    br_base   = is_br ? br_value : rsp_pc_q;
    br_sum    = br_base + br_off;
    br_target = {br_sum[31:2], 2'b00};
    br_taken  = is_b | is_br;
  end
`else
  logic unused_br_value;
  assign unused_br_value = ^br_value;

  // No early decode: words pass through and the register port is idle.
  always_comb begin
    br_addr   = 3'b000;
    br_target = '0;
    br_taken  = 1'b0;
  end
`endif

  // Next-state: PC selection, response tracking and FIFO pointers/head.
  always_comb begin
    // A redirect discards everything younger than itself, including a branch found this cycle.
    enq        = rsp_valid_q & ~redir_valid;
    deq        = instr_valid & instr_ready & ~redir_valid;
    branch_act = br_taken & ~redir_valid;

    // The request issued alongside a redirect or taken branch is wrong-path; drop its response.
    rsp_valid_d = im_req & ~redir_valid & ~branch_act;
    rsp_pc_d    = fetch_pc_q;

    fetch_pc_d = fetch_pc_q;
    if (redir_valid)     fetch_pc_d = {redir_pc[31:2], 2'b00};
    else if (branch_act) fetch_pc_d = br_target;
    else if (im_req)     fetch_pc_d = fetch_pc_q + 32'd4;

    rd_ptr_d = rd_ptr_q + PtrW'(deq);
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    count_d  = count_q + CntW'(enq) - CntW'(deq);
    if (redir_valid) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    // Head register tracks the entry that will be at rd_ptr next cycle; when that entry is the
    // one being written right now it is taken straight from the response.
    head_bypass  = enq && (count_q == CntW'(deq));
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    if (count_d != '0) begin
      head_instr_d = head_bypass ? im_rdata : mem_instr_q[rd_ptr_d];
      head_pc_d    = head_bypass ? rsp_pc_q : mem_pc_q[rd_ptr_d];
    end
  end

  // Control and head state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      fetch_pc_q   <= ResetPcAligned;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr_q[wr_ptr_q] <= im_rdata;
      mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: an IM model answers one cycle after each request,
// a scoreboard queue holds the expected (pc, word) stream and per-scenario tasks check timing.
module tb_if_prefetch_unit;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] ResetPc = 32'h100;
`ifdef IF_EARLY_BRANCH_EN
  localparam bit EarlyBr = 1'b1;
`else
  localparam bit EarlyBr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [2:0]  br_addr;
  logic [31:0] br_value;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] prog [logic [31:0]];
  logic [63:0] sbq [$];
  bit          sb_en = 1'b0;
  logic        pend_req = 1'b0;
  logic [31:0] pend_addr = '0;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .DEPTH    (Depth),
    .RESET_PC (ResetPc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .br_addr     (br_addr),
    .br_value    (br_value)
  );

  // Register file model: only r5 is non-zero.
  assign br_value = (br_addr == 3'd5) ? 32'h0000_2000 : 32'h0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {8'h13, a[23:0]};
  endfunction

  // IM model: capture the request mid-cycle, return the word in the following cycle.
  always @(negedge clk) begin
    pend_req  = im_req;
    pend_addr = im_addr;
  end
  always @(posedge clk) begin
    #1;
    im_rdata = pend_req ? imem(pend_addr) : 32'h0;
  end

  // Scoreboard: every accepted instruction is compared with the next expected entry.
  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (sb_en && !reset && instr_valid && instr_ready && !redir_valid) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got pc %h, expected no further instruction", instr_pc);
        sb_en = 1'b0;
      end else begin
        exp_v = sbq.pop_front();
        if ({instr_pc, instr_out} !== exp_v) begin
          n_err++;
          $display("FAIL sb_stream: got pc %h instr %h, expected pc %h instr %h",
                   instr_pc, instr_out, exp_v[63:32], exp_v[31:0]);
        end
        if (sbq.size() == 0) sb_en = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sbq.push_back({pc, imem(pc)});
  endtask

  // Two reset edges, then release; returns at the start of cycle 0.
  task automatic start(input logic rdy);
    sb_en = 1'b0;
    sbq.delete();
    redir_valid = 1'b0;
    redir_pc = '0;
    instr_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    instr_ready = rdy;
  endtask

  task automatic test_reset();
    prog.delete();
    sb_en = 1'b0;
    sbq.delete();
    redir_valid = 1'b0;
    redir_pc = '0;
    instr_ready = 1'b1;
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if ({im_req, instr_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_req_valid: got %b expected 00", {im_req, instr_valid});
    end
    n_vec++;
    if ({instr_out, instr_pc} !== 64'h0) begin
      n_err++;
      $display("FAIL rst_out_pc: got %h expected 0", {instr_out, instr_pc});
    end
    n_vec++;
    if (br_addr !== 3'd0) begin
      n_err++;
      $display("FAIL rst_br_addr: got %0d expected 0", br_addr);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({im_req, im_addr} !== {1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL rst_first_req: got %b/%h expected 1/00000100", im_req, im_addr);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid_c1: got %b expected 0", instr_valid);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({instr_valid, instr_pc, instr_out} !== {1'b1, 32'h100, imem(32'h100)}) begin
      n_err++;
      $display("FAIL rst_valid_c2: got %b/%h/%h expected 1/00000100/%h",
               instr_valid, instr_pc, instr_out, imem(32'h100));
    end
    tick();
  endtask

  task automatic test_stream();
    prog.delete();
    start(1'b1);
    for (int k = 0; k < 8; k++) push_exp(32'h100 + 32'(4 * k));
    sb_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if ({im_req, im_addr} !== {1'b1, 32'h100 + 32'(4 * c)}) begin
        n_err++;
        $display("FAIL stream_addr c%0d: got %b/%h expected 1/%h", c, im_req, im_addr,
                 32'h100 + 32'(4 * c));
      end
      if (c >= 2) begin
        n_vec++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h100 + 32'(4 * (c - 2))}) begin
          n_err++;
          $display("FAIL stream_pc c%0d: got %b/%h expected 1/%h", c, instr_valid, instr_pc,
                   32'h100 + 32'(4 * (c - 2)));
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && sb_en; i++) @(negedge clk);
    n_vec++;
    if (sb_en) begin
      n_err++;
      $display("FAIL stream_drain: got %0d pending expected 0", sbq.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    prog.delete();
    start(1'b0);
    for (int k = 0; k < 8; k++) push_exp(32'h100 + 32'(4 * k));
    sb_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (im_req !== (c < 4)) begin
        n_err++;
        $display("FAIL bp_req c%0d: got %b expected %b", c, im_req, (c < 4));
      end
      if (c >= 2) begin
        n_vec++;
        if ({instr_valid, instr_pc, instr_out} !== {1'b1, 32'h100, imem(32'h100)}) begin
          n_err++;
          $display("FAIL bp_hold c%0d: got %b/%h/%h expected 1/00000100/%h", c, instr_valid,
                   instr_pc, instr_out, imem(32'h100));
        end
      end
      tick();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if ({instr_valid, instr_pc} !== {1'b1, 32'h100 + 32'(4 * k)}) begin
        n_err++;
        $display("FAIL bp_release k%0d: got %b/%h expected 1/%h", k, instr_valid, instr_pc,
                 32'h100 + 32'(4 * k));
      end
      tick();
    end
    for (int i = 0; i < 40 && sb_en; i++) @(negedge clk);
    n_vec++;
    if (sb_en) begin
      n_err++;
      $display("FAIL bp_drain: got %0d pending expected 0", sbq.size());
    end
    tick();
  endtask

  task automatic test_branch_b();
    logic [31:0] exp_pcs [8];
    prog.delete();
    prog[32'h110] = 32'hC000_FFF8;
    start(1'b1);
    if (EarlyBr) exp_pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h108, 32'h10C,
                             32'h110};
    else         exp_pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
                             32'h11C};
    for (int k = 0; k < 8; k++) push_exp(exp_pcs[k]);
    sb_en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 5) begin
        n_vec++;
        if (im_addr !== 32'h114) begin
          n_err++;
          $display("FAIL b_shadow_addr: got %h expected 00000114", im_addr);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (im_addr !== (EarlyBr ? 32'h108 : 32'h118)) begin
          n_err++;
          $display("FAIL b_target_addr: got %h expected %h", im_addr,
                   EarlyBr ? 32'h108 : 32'h118);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (instr_valid !== !EarlyBr) begin
          n_err++;
          $display("FAIL b_bubble: got %b expected %b", instr_valid, !EarlyBr);
        end
      end
      if (c == 8) begin
        n_vec++;
        if (instr_pc !== (EarlyBr ? 32'h108 : 32'h118)) begin
          n_err++;
          $display("FAIL b_target_pc: got %h expected %h", instr_pc,
                   EarlyBr ? 32'h108 : 32'h118);
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && sb_en; i++) @(negedge clk);
    n_vec++;
    if (sb_en) begin
      n_err++;
      $display("FAIL b_drain: got %0d pending expected 0", sbq.size());
    end
    tick();
  endtask

  task automatic test_branch_br();
    logic [31:0] exp_pcs [8];
    prog.delete();
    prog[32'h110] = 32'hC540_0010;
    start(1'b1);
    if (EarlyBr) exp_pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h2010, 32'h2014,
                             32'h2018};
    else         exp_pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
                             32'h11C};
    for (int k = 0; k < 8; k++) push_exp(exp_pcs[k]);
    sb_en = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 5) begin
        n_vec++;
        if (br_addr !== (EarlyBr ? 3'd5 : 3'd0)) begin
          n_err++;
          $display("FAIL br_addr: got %0d expected %0d", br_addr, EarlyBr ? 5 : 0);
        end
        n_vec++;
        if (im_addr !== 32'h114) begin
          n_err++;
          $display("FAIL br_shadow_addr: got %h expected 00000114", im_addr);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (im_addr !== (EarlyBr ? 32'h2010 : 32'h118)) begin
          n_err++;
          $display("FAIL br_target_addr: got %h expected %h", im_addr,
                   EarlyBr ? 32'h2010 : 32'h118);
        end
      end
      if (c == 8) begin
        n_vec++;
        if (instr_pc !== (EarlyBr ? 32'h2010 : 32'h118)) begin
          n_err++;
          $display("FAIL br_target_pc: got %h expected %h", instr_pc,
                   EarlyBr ? 32'h2010 : 32'h118);
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && sb_en; i++) @(negedge clk);
    n_vec++;
    if (sb_en) begin
      n_err++;
      $display("FAIL br_drain: got %0d pending expected 0", sbq.size());
    end
    tick();
  endtask

  task automatic test_redirect();
    prog.delete();
    start(1'b0);
    for (int c = 0; c < 9; c++) begin
      if (c == 4) begin
        instr_ready = 1'b1;
        redir_valid = 1'b1;
        redir_pc = 32'h403;
      end
      if (c == 5) begin
        redir_valid = 1'b0;
        for (int k = 0; k < 4; k++) push_exp(32'h400 + 32'(4 * k));
        sb_en = 1'b1;
      end
      @(negedge clk);
      if (c == 4) begin
        n_vec++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h100}) begin
          n_err++;
          $display("FAIL rd_pre_head: got %b/%h expected 1/00000100", instr_valid, instr_pc);
        end
      end
      if (c == 5) begin
        n_vec++;
        if ({im_req, im_addr, instr_valid} !== {1'b1, 32'h400, 1'b0}) begin
          n_err++;
          $display("FAIL rd_flush_req: got %b/%h/%b expected 1/00000400/0", im_req, im_addr,
                   instr_valid);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (instr_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rd_gap: got %b expected 0", instr_valid);
        end
      end
      if (c == 7) begin
        n_vec++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h400}) begin
          n_err++;
          $display("FAIL rd_target: got %b/%h expected 1/00000400", instr_valid, instr_pc);
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && sb_en; i++) @(negedge clk);
    n_vec++;
    if (sb_en) begin
      n_err++;
      $display("FAIL rd_drain: got %0d pending expected 0", sbq.size());
    end
    tick();
  endtask

  task automatic test_redir_wrap_reset();
    prog.delete();
    prog[32'h110] = 32'hC000_FFF8;
    start(1'b1);
    push_exp(32'h100);
    push_exp(32'h104);
    push_exp(32'h108);
    sb_en = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 5) begin
        redir_valid = 1'b1;
        redir_pc = 32'hFFFF_FFFE;
      end
      if (c == 6) begin
        redir_valid = 1'b0;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        push_exp(32'h4);
        sb_en = 1'b1;
      end
      if (c == 11) reset = 1'b1;
      @(negedge clk);
      if (c == 6) begin
        n_vec++;
        if (im_addr !== 32'hFFFF_FFFC) begin
          n_err++;
          $display("FAIL wrap_redir_wins: got %h expected fffffffc", im_addr);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (im_addr !== 32'h0) begin
          n_err++;
          $display("FAIL wrap_addr: got %h expected 00000000", im_addr);
        end
      end
      if (c == 8) begin
        n_vec++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
          n_err++;
          $display("FAIL wrap_pc0: got %b/%h expected 1/fffffffc", instr_valid, instr_pc);
        end
      end
      if (c == 9) begin
        n_vec++;
        if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin
          n_err++;
          $display("FAIL wrap_pc1: got %b/%h expected 1/00000000", instr_valid, instr_pc);
        end
      end
      if (c == 11) begin
        n_vec++;
        if (sb_en) begin
          n_err++;
          $display("FAIL wrap_drain: got %0d pending expected 0", sbq.size());
        end
      end
      if (c == 12) begin
        n_vec++;
        if ({instr_valid, im_req} !== 2'b00) begin
          n_err++;
          $display("FAIL mid_reset: got %b expected 00", {instr_valid, im_req});
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc = '0;
    im_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_b();
    test_branch_br();
    test_redirect();
    test_redir_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
